// File: rtl/step_sequencer.sv
// Drum-machine step sequencer: loads the tempo generator with a 3-cycle strobe and
// steps a STEPS x TRACKS pattern on every accepted tick, emitting one-cycle triggers.
module step_sequencer #(
  parameter  int STEPS  = 16,
  parameter  int TRACKS = 4,
  localparam int AW     = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [7:0]        bpm_in,
  input  logic              bpm_set,
  input  logic              play,
  input  logic              stop,
  input  logic              pat_we,
  input  logic [AW-1:0]     pat_addr,
  input  logic [TRACKS-1:0] pat_data,
  output logic [7:0]        bpm_out,
  output logic              load_bpm,
  output logic [AW-1:0]     step,
  output logic [TRACKS-1:0] trig,
  output logic              bar_pulse,
  output logic              running
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LOAD} state_e;

  state_e                        state_q, ret_q;
  logic [1:0]                    cnt_q;
  logic [7:0]                    bpm_q;
  logic                          load_q, bar_q, running_q;
  logic [AW-1:0]                 step_q;
  logic [TRACKS-1:0]             trig_q;
  logic [STEPS-1:0][TRACKS-1:0]  pat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ret_q     <= IDLE;
      cnt_q     <= '0;
      bpm_q     <= 8'd60;
      load_q    <= 1'b0;
      bar_q     <= 1'b0;
      running_q <= 1'b0;
      step_q    <= '0;
      trig_q    <= '0;
      pat_q     <= '0;
    end else begin
      trig_q <= '0;
      bar_q  <= 1'b0;
      // Non-blocking write keeps a same-cycle tick reading the old step data.
      if (pat_we) pat_q[pat_addr] <= pat_data;

      if (stop) begin
        step_q <= '0;
        running_q <= 1'b0;
        if (state_q == LOAD) begin
          // The strobe still runs to completion; only the destination changes.
          ret_q <= IDLE;
          if (cnt_q == 2'd2) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end else begin
          state_q <= IDLE;
        end
      end else if (bpm_set) begin
        bpm_q   <= (bpm_in == 8'd0) ? 8'd60 : bpm_in;
        cnt_q   <= '0;
        load_q  <= 1'b1;
        state_q <= LOAD;
        if (state_q != LOAD) begin
          ret_q     <= state_q;
          running_q <= (state_q == RUN);
        end
      end else begin
        case (state_q)
          LOAD: begin
            if (cnt_q == 2'd2) begin
              state_q <= ret_q;
              load_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
          IDLE: begin
            if (play) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            if (play) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end else if (tick) begin
              trig_q <= pat_q[step_q];
              bar_q  <= (step_q == '0);
              step_q <= step_q + 1'b1;
            end
          end
          PAUSE: begin
            if (play) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bpm_out   = bpm_q;
  assign load_bpm  = load_q;
  assign step      = step_q;
  assign trig      = trig_q;
  assign bar_pulse = bar_q;
  assign running   = running_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed feature scenarios plus a randomized run
// checked against a cycle-level behavioural model of the sequencer rules.
module tb_step_sequencer;

  logic       clk = 1'b0, reset = 1'b1;
  logic       tick = 1'b0, bpm_set = 1'b0, play = 1'b0, stop = 1'b0, pat_we = 1'b0;
  logic [7:0] bpm_in = '0;
  logic [3:0] pat_addr = '0, pat_data = '0;
  logic [7:0] bpm_out;
  logic       load_bpm, bar_pulse, running;
  logic [3:0] step, trig;

  int n_tests = 0, n_fail = 0;

  step_sequencer #(.STEPS(16), .TRACKS(4)) dut (
    .clk(clk), .reset(reset), .tick(tick), .bpm_in(bpm_in), .bpm_set(bpm_set),
    .play(play), .stop(stop), .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
    .bpm_out(bpm_out), .load_bpm(load_bpm), .step(step), .trig(trig),
    .bar_pulse(bar_pulse), .running(running)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=stopped, 1=playing, 2=paused; loading overlays a mode.
  int         m_mode, m_ret, m_step, m_bpm, m_left;
  bit         m_loading, m_bar;
  logic [3:0] m_trig;
  logic [3:0] m_pat [16];

  function automatic void model_reset();
    m_mode = 0; m_ret = 0; m_step = 0; m_bpm = 60; m_left = 0;
    m_loading = 0; m_bar = 0; m_trig = '0;
    for (int i = 0; i < 16; i++) m_pat[i] = '0;
  endfunction

  function automatic void load_count();
    m_left--;
    if (m_left == 0) begin
      m_loading = 0;
      m_mode = m_ret;
    end
  endfunction

  function automatic void model_edge();
    logic [3:0] old;
    old = m_pat[m_step];
    m_trig = '0;
    m_bar = 0;
    if (stop) begin
      m_step = 0;
      if (m_loading) begin
        m_ret = 0;
        load_count();
      end else m_mode = 0;
    end else if (bpm_set) begin
      m_bpm = (bpm_in == 0) ? 60 : int'(bpm_in);
      if (!m_loading) m_ret = m_mode;
      m_loading = 1;
      m_left = 3;
    end else if (m_loading) begin
      load_count();
    end else if (play) begin
      m_mode = (m_mode == 1) ? 2 : 1;
    end else if (tick && m_mode == 1) begin
      m_trig = old;
      m_bar = (m_step == 0);
      m_step = (m_step + 1) % 16;
    end
    if (pat_we) m_pat[pat_addr] = pat_data;
  endfunction

  function automatic logic [18:0] exp_vec();
    bit run;
    run = m_loading ? (m_ret == 1) : (m_mode == 1);
    return {8'(m_bpm), m_loading, 4'(m_step), m_trig, m_bar, run};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    tick = 0; play = 0; stop = 0; bpm_set = 0; pat_we = 0;
  endtask

  task automatic test_reset();
    reset = 1; #2 reset = 0; #3;
    n_tests++; if (bpm_out !== 8'd60) begin n_fail++; $display("FAIL reset_bpm got %0d want 60", bpm_out); end
    n_tests++; if (step !== 4'd0) begin n_fail++; $display("FAIL reset_step got %0d want 0", step); end
    n_tests++; if ({trig, bar_pulse, load_bpm, running} !== 7'd0)
      begin n_fail++; $display("FAIL reset_flags got %b want 0000000", {trig, bar_pulse, load_bpm, running}); end
    model_reset();
    @(negedge clk) reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick = 1; cyc();
      n_tests++; if (trig !== 4'd0) begin n_fail++; $display("FAIL idle_tick got %b want 0000", trig); end
      cyc();
    end
  endtask

  task automatic test_tempo_load();
    int hi, first;
    for (int r = 0; r < 2; r++) begin
      bpm_in = (r == 0) ? 8'd90 : 8'd0;
      bpm_set = 1; cyc();
      first = load_bpm; hi = load_bpm;
      n_tests++; if (bpm_out !== ((r == 0) ? 8'd90 : 8'd60))
        begin n_fail++; $display("FAIL tempo_bpm got %0d want %0d", bpm_out, (r == 0) ? 90 : 60); end
      for (int i = 0; i < 5; i++) begin cyc(); hi += int'(load_bpm); end
      n_tests++; if (first != 1 || hi != 3)
        begin n_fail++; $display("FAIL tempo_strobe got first=%0d cycles=%0d want first=1 cycles=3", first, hi); end
    end
  endtask

  task automatic test_playback_wrap();
    logic [3:0] et;
    logic       eb;
    pat_we = 1; pat_addr = 0;  pat_data = 4'b0001; cyc();
    pat_we = 1; pat_addr = 15; pat_data = 4'b1000; cyc();
    play = 1; cyc();
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL play_running got %b want 1", running); end
    for (int k = 1; k <= 17; k++) begin
      tick = 1; cyc();
      et = (k == 1 || k == 17) ? 4'b0001 : (k == 16) ? 4'b1000 : 4'b0000;
      eb = (k == 1 || k == 17);
      n_tests++; if (trig !== et || bar_pulse !== eb)
        begin n_fail++; $display("FAIL wrap_tick%0d got trig=%b bar=%b want trig=%b bar=%b", k, trig, bar_pulse, et, eb); end
      cyc();
    end
    n_tests++; if (step !== 4'd1) begin n_fail++; $display("FAIL wrap_step got %0d want 1", step); end
  endtask

  task automatic test_pause_stop();
    for (int i = 0; i < 4; i++) begin tick = 1; cyc(); cyc(); end
    n_tests++; if (step !== 4'd5) begin n_fail++; $display("FAIL pause_pre_step got %0d want 5", step); end
    play = 1; cyc();
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running got %b want 0", running); end
    pat_we = 1; pat_addr = 5; pat_data = 4'b0110; cyc();
    for (int i = 0; i < 4; i++) begin
      tick = 1; cyc();
      n_tests++; if (trig !== 4'd0 || step !== 4'd5)
        begin n_fail++; $display("FAIL pause_tick got trig=%b step=%0d want trig=0000 step=5", trig, step); end
      cyc();
    end
    play = 1; cyc();
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL resume_running got %b want 1", running); end
    tick = 1; cyc();
    n_tests++; if (trig !== 4'b0110 || step !== 4'd6)
      begin n_fail++; $display("FAIL resume_fire got trig=%b step=%0d want trig=0110 step=6", trig, step); end
    cyc();
    stop = 1; cyc();
    n_tests++; if (step !== 4'd0 || running !== 1'b0)
      begin n_fail++; $display("FAIL stop got step=%0d running=%b want 0 0", step, running); end
  endtask

  task automatic test_simultaneous();
    play = 1; cyc();
    tick = 1; cyc(); cyc();
    stop = 1; play = 1; tick = 1; cyc();
    n_tests++; if (trig !== 4'd0 || step !== 4'd0 || running !== 1'b0)
      begin n_fail++; $display("FAIL stop_play_tick got trig=%b step=%0d run=%b want 0000 0 0", trig, step, running); end
    play = 1; cyc();
    bpm_in = 8'd120; bpm_set = 1; cyc();
    n_tests++; if (running !== 1'b1 || load_bpm !== 1'b1)
      begin n_fail++; $display("FAIL load_in_run got run=%b load=%b want 1 1", running, load_bpm); end
    tick = 1; cyc();
    n_tests++; if (trig !== 4'd0 || running !== 1'b1)
      begin n_fail++; $display("FAIL load_tick_drop got trig=%b run=%b want 0000 1", trig, running); end
    cyc(); cyc();
    n_tests++; if (load_bpm !== 1'b0 || running !== 1'b1)
      begin n_fail++; $display("FAIL load_return got load=%b run=%b want 0 1", load_bpm, running); end
    tick = 1; cyc();
    n_tests++; if (trig !== 4'b0001 || bar_pulse !== 1'b1)
      begin n_fail++; $display("FAIL post_load_tick got trig=%b bar=%b want 0001 1", trig, bar_pulse); end
    cyc();
  endtask

  task automatic test_collision_async_reset();
    pat_we = 1; pat_addr = 1; pat_data = 4'b0101; cyc();
    tick = 1; pat_we = 1; pat_addr = 1; pat_data = 4'b1010; cyc();
    n_tests++; if (trig !== 4'b0101) begin n_fail++; $display("FAIL collision got %b want 0101", trig); end
    cyc();
    bpm_in = 8'd200; bpm_set = 1; cyc();
    n_tests++; if (load_bpm !== 1'b1) begin n_fail++; $display("FAIL preload got %b want 1", load_bpm); end
    #2 reset = 0; #1;
    n_tests++; if (load_bpm !== 1'b0 || bpm_out !== 8'd60 || running !== 1'b0 || step !== 4'd0)
      begin n_fail++; $display("FAIL async_reset got load=%b bpm=%0d run=%b step=%0d want 0 60 0 0",
                               load_bpm, bpm_out, running, step); end
    model_reset();
    @(negedge clk) reset = 1;
  endtask

  task automatic test_random();
    bit prev_tick = 0;
    logic [18:0] got;
    for (int i = 0; i < 3000; i++) begin
      tick     = !prev_tick && ($urandom_range(0, 2) == 0);
      play     = ($urandom_range(0, 15) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      bpm_set  = ($urandom_range(0, 49) == 0);
      bpm_in   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      pat_we   = ($urandom_range(0, 3) == 0);
      pat_addr = 4'($urandom);
      pat_data = 4'($urandom);
      prev_tick = tick;
      cyc();
      got = {bpm_out, load_bpm, step, trig, bar_pulse, running};
      n_tests++; if (got !== exp_vec())
        begin n_fail++; $display("FAIL random_cycle%0d got %h want %h", i, got, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_tempo_load();
    test_playback_wrap();
    test_pause_stop();
    test_simultaneous();
    test_collision_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Pattern step sequencer and tempo controller for the drum-machine datapath. It configures the tempo generator by latching the user BPM and driving the generator's load strobe for exactly 3 cycles. It then consumes the generator's eighth-note tick pulses to walk a 16-step, 4-track pattern register file, emitting one-cycle per-track triggers to the sound blocks. Play, pause, stop and pattern editing come from the board's keys and switches.

## Interface
- `STEPS`, 16: pattern length; must be a power of two.
- `TRACKS`, 4: number of trigger outputs, one per pattern bit.
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle pulse from the tempo generator at eighth-note rate.
- `bpm_in`  in  8  user tempo from the switches.
- `bpm_set`  in  1  one-cycle pulse requesting that `bpm_in` be applied.
- `play`  in  1  one-cycle pulse that starts or toggles pause.
- `stop`  in  1  one-cycle pulse that halts playback and rewinds to step 0.
- `pat_we`  in  1  pattern write enable.
- `pat_addr`  in  log2(STEPS)  step address to write.
- `pat_data`  in  TRACKS  track bits for that step.
- `bpm_out`  out  8  held tempo value driven to the generator.
- `load_bpm`  out  1  load strobe to the generator.
- `step`  out  log2(STEPS)  index of the next step to fire.
- `trig`  out  TRACKS  one-cycle trigger pulses.
- `bar_pulse`  out  1  one-cycle pulse when step 0 fires.
- `running`  out  1  high when playback is active.

## Operation
- **States:** IDLE, RUN, PAUSE, LOAD.
  - LOAD records a return state `ret` (IDLE, RUN or PAUSE) and uses a 2-bit cycle counter.
- **Reset (asynchronous):**
  - State is IDLE and `ret` is IDLE.
  - `step`=0, `trig`=0, `bar_pulse`=0, `load_bpm`=0, `running`=0.
  - `bpm_out`=8'd60.
  - All pattern bits are cleared to 0.
- **bpm_set (any state, including LOAD):**
  - Latch `bpm_out` ← `bpm_in`, except that 0 is replaced by 60.
  - Enter LOAD and restart the counter.
  - `ret` is set to the current state, or kept unchanged if already in LOAD.
- **LOAD:**
  - `load_bpm`=1 for exactly 3 consecutive cycles, so the generator's beat, max_count and count registers all settle.
  - Then return to `ret`.
  - `tick` is dropped and `play` is ignored.
  - `stop` sets `ret`=IDLE and `step`=0; LOAD still completes.
- **IDLE:** `play` → RUN with `step` unchanged (0). `tick` is ignored.
- **RUN:**
  - On `tick`, in the next cycle:
    - `trig` = pattern[`step`] for 1 cycle.
    - `bar_pulse` = (`step`==0).
    - `step` = (`step`+1) mod STEPS, so STEPS-1 wraps to 0.
  - `play` → PAUSE.
- **PAUSE:** `step` is held and `tick` is ignored. `play` → RUN.
- **stop (outside LOAD):** → IDLE, `step`=0, and no trigger is issued that cycle.
- **Priority for same-cycle events:** `stop` > `bpm_set` > `play` > `tick`. The lower-priority events in that cycle are discarded.
- **Pattern write:**
  - When `pat_we`=1, pattern[`pat_addr`] ← `pat_data` at the clock edge. Writes are accepted in every state.
  - If a write and a `tick` address the same step in one cycle, `trig` uses the old data (read-before-write).
- **running:** 1 in RUN, and 1 in LOAD when `ret`=RUN. Otherwise 0.

## Timing
- All outputs are registered. Trigger latency is 1 cycle from `tick`.
- `load_bpm` rises on the cycle after `bpm_set` and stays high for 3 cycles.
- The first `tick` accepted after LOAD is the one that arrives in the cycle after `load_bpm` falls.
- `trig` and `bar_pulse` are never high for more than 1 consecutive cycle.
- A `tick` arriving in the same cycle as the PAUSE→RUN transition is ignored. Acceptance resumes the following cycle.
- Asserting `reset` mid-LOAD or mid-RUN clears all outputs immediately, without waiting for a clock edge.

## Test plan
- **Reset defaults:** assert `reset`=0 then release → `bpm_out`=60, `step`=0, `trig`=0, `load_bpm`=0, `running`=0. Then 3 `tick`s in IDLE → no `trig`.
- **Tempo load:** `bpm_set` with `bpm_in`=90 → `bpm_out`=90 and `load_bpm` high for exactly 3 cycles starting 1 cycle later. Repeat with `bpm_in`=0 → `bpm_out`=60.
- **Playback and wrap:**
  - Write pattern[0]=4'b0001 and pattern[15]=4'b1000, then `play`, then 17 ticks.
  - Expected: `trig`=0001 with `bar_pulse`=1 after tick 1; `trig`=1000 after tick 16; `trig`=0001 with `bar_pulse`=1 after tick 17; `step`=1 at the end.
- **Pause and stop:**
  - At `step`=5: `play` → PAUSE; 4 ticks leave `step`=5 with no `trig`.
  - `play` then resumes RUN; the next tick fires step 5.
  - `stop` → `step`=0, `running`=0.
- **Simultaneous events:**
  - `stop`+`play`+`tick` in the same cycle while in RUN → IDLE, no `trig`.
  - `bpm_set` in RUN → `running` stays 1 through LOAD, a tick arriving during LOAD is dropped, and the state returns to RUN.
- **Write/read collision and async reset:**
  - `pat_we` to the current step in the same cycle as `tick` → old data appears on `trig`.
  - `reset` asserted mid-LOAD → `load_bpm` drops to 0 immediately.
